// File: rtl/segment_tally.sv
// rtl/segment_tally.sv - per-frame lit-pixel tally for six digit windows, drained over valid/ready
module segment_tally #(
  parameter logic [5:0] THRESH = 6'd24,
  parameter int         CNT_W  = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       hcnt,
  input  logic [9:0]       vcnt,
  input  logic             pixEn,
  input  logic [11:0]      pixelIn,
  input  logic             ready,
  output logic             valid,
  output logic [2:0]       digitIdx,
  output logic [CNT_W-1:0] count,
  output logic             frameDone,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [9:0] ROW_FIRST = 10'd151;
  localparam logic [9:0] ROW_LAST  = 10'd299;
  localparam logic [9:0] SNAP_ROW  = 10'd300;
  localparam logic [9:0] COL_LO [6] = '{10'd51, 10'd141, 10'd231, 10'd336, 10'd426, 10'd516};
  localparam logic [9:0] COL_HI [6] = '{10'd124, 10'd214, 10'd304, 10'd409, 10'd499, 10'd589};

  typedef enum logic {IDLE, EMIT} stateT;

  stateT            state;
  logic [CNT_W-1:0] acc  [6];
  logic [CNT_W-1:0] hold [6];

  logic [6:0] pixSum;
  logic       pixLit;
  logic       rowHit;
  logic [5:0] winHit;
  logic       snapEvt;
  logic       accept;
  logic       lastAccept;
  logic       snapTake;
  logic [2:0] nextIdx;

  assign pixSum = {3'b000, pixelIn[11:8]} + {3'b000, pixelIn[7:4]} + {3'b000, pixelIn[3:0]};
  assign pixLit = pixSum >= {1'b0, THRESH};
  assign rowHit = (vcnt >= ROW_FIRST) && (vcnt <= ROW_LAST);

  for (genvar k = 0; k < 6; k++) begin : gWin
    assign winHit[k] = rowHit && (hcnt >= COL_LO[k]) && (hcnt <= COL_HI[k]);
  end

  // The snapshot point lies outside every window, so clearing acc never drops a pixel.
  assign snapEvt    = pixEn && (vcnt == SNAP_ROW) && (hcnt == 10'd0);
  assign accept     = valid && ready;
  assign lastAccept = accept && (digitIdx == 3'd5);
  assign snapTake   = snapEvt && ((state == IDLE) || lastAccept);
  assign nextIdx    = digitIdx + 3'd1;

  always_ff @(posedge clk) begin
    for (int k = 0; k < 6; k++) begin
      if (rst || snapEvt) begin
        acc[k] <= '0;
      end else if (pixEn && pixLit && winHit[k] && (acc[k] != CNT_MAX)) begin
        acc[k] <= acc[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 6; k++) begin
      if (rst) begin
        hold[k] <= '0;
      end else if (snapTake) begin
        hold[k] <= acc[k];
      end
    end
  end

  // digitIdx doubles as the drain index; count tracks hold[digitIdx] one step ahead.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= 1'b0;
      digitIdx  <= 3'd0;
      count     <= '0;
      frameDone <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frameDone <= lastAccept;
      overrun   <= snapEvt && !snapTake;
      if (snapTake) begin
        state    <= EMIT;
        valid    <= 1'b1;
        digitIdx <= 3'd0;
        count    <= acc[0];
      end else if (accept) begin
        if (digitIdx != 3'd5) begin
          digitIdx <= nextIdx;
          count    <= hold[nextIdx];
        end else begin
          state    <= IDLE;
          valid    <= 1'b0;
          digitIdx <= 3'd0;
          count    <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_segment_tally.sv
// tb/tb_segment_tally.sv - randomized and directed bench for segment_tally against a queue model
module tb_segment_tally;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic        pixEn;
  logic [11:0] pixelIn;
  logic        ready;
  logic        valid;
  logic [2:0]  digitIdx;
  logic [13:0] count;
  logic        frameDone;
  logic        overrun;

  segment_tally dut (
    .clk(clk), .rst(rst), .hcnt(hcnt), .vcnt(vcnt), .pixEn(pixEn),
    .pixelIn(pixelIn), .ready(ready), .valid(valid), .digitIdx(digitIdx),
    .count(count), .frameDone(frameDone), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int colLo [6] = '{51, 141, 231, 336, 426, 516};
  int colHi [6] = '{124, 214, 304, 409, 499, 589};
  int expAcc [6];
  int outQ [$];

  function automatic int winOf(input int h, input int v);
    if (v < 151 || v > 299) return -1;
    for (int k = 0; k < 6; k++)
      if (h >= colLo[k] && h <= colHi[k]) return k;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic clearModel();
    outQ.delete();
    for (int k = 0; k < 6; k++) expAcc[k] = 0;
  endtask

  task automatic step(input logic en, input int h, input int v, input logic [11:0] pix, input logic rdy);
    bit hs, snap, expFd, expOv;
    int k, sum;
    pixEn = en; hcnt = h[9:0]; vcnt = v[9:0]; pixelIn = pix; ready = rdy;
    hs    = (outQ.size() > 0) && rdy;
    expFd = hs && (outQ.size() == 1);
    if (hs) void'(outQ.pop_front());
    snap  = en && (v == 300) && (h == 0);
    expOv = 1'b0;
    if (snap) begin
      if (outQ.size() == 0) begin
        for (int j = 0; j < 6; j++) outQ.push_back(expAcc[j]);
      end else begin
        expOv = 1'b1;
      end
      for (int j = 0; j < 6; j++) expAcc[j] = 0;
    end else if (en) begin
      k   = winOf(h, v);
      sum = int'(pix[11:8]) + int'(pix[7:4]) + int'(pix[3:0]);
      if (k >= 0 && sum >= 24 && expAcc[k] < 16383) expAcc[k]++;
    end
    @(posedge clk); #1;
    check("valid", valid, outQ.size() != 0);
    if (outQ.size() != 0) begin
      check("digitIdx", digitIdx, 6 - outQ.size());
      check("count", count, outQ[0]);
    end
    check("frameDone", frameDone, expFd);
    check("overrun", overrun, expOv);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 12'h000, rdy);
  endtask

  task automatic snapshot(input logic rdy);
    step(1'b1, 0, 300, 12'h000, rdy);
  endtask

  task automatic randPix(input logic rdy);
    logic en;
    int h, v;
    en = ($urandom_range(0, 7) != 0);
    h  = $urandom_range(40, 600);
    v  = $urandom_range(140, 310);
    if (!en && $urandom_range(0, 3) == 0) begin h = 0; v = 300; end
    step(en, h, v, 12'($urandom), rdy);
  endtask

  task automatic randFrame(input int n, input bit randReady);
    for (int i = 0; i < n; i++) randPix(randReady ? ($urandom_range(0, 9) < 7) : 1'b1);
  endtask

  task automatic doReset();
    rst = 1'b1; pixEn = 1'b0; ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    clearModel();
    check("rst_valid", valid, 0);
    check("rst_digitIdx", digitIdx, 0);
    check("rst_count", count, 0);
    check("rst_frameDone", frameDone, 0);
    check("rst_overrun", overrun, 0);
  endtask

  initial begin
    rst = 1'b1; pixEn = 1'b0; hcnt = '0; vcnt = '0; pixelIn = '0; ready = 1'b0;
    clearModel();
    doReset();
    idle(3, 1'b1);

    // window 2 fully at threshold, everything else just below or outside the windows
    for (int v = 151; v <= 299; v++)
      for (int h = 231; h <= 304; h++) step(1'b1, h, v, 12'h888, 1'b1);
    for (int i = 0; i < 300; i++)
      step(1'b1, $urandom_range(40, 600), $urandom_range(140, 310), 12'h887, 1'b1);
    for (int i = 0; i < 100; i++)
      step(1'b1, $urandom_range(125, 140), $urandom_range(151, 299), 12'hFFF, 1'b1);
    snapshot(1'b1);
    idle(8, 1'b1);

    // window-edge pixels
    step(1'b1, 50, 151, 12'hFFF, 1'b1);
    step(1'b1, 51, 151, 12'hFFF, 1'b1);
    step(1'b1, 124, 299, 12'hFFF, 1'b1);
    step(1'b1, 125, 299, 12'hFFF, 1'b1);
    step(1'b1, 51, 150, 12'hFFF, 1'b1);
    step(1'b1, 589, 300, 12'hFFF, 1'b1);
    for (int i = 0; i < 200; i++)
      step(1'b1, $urandom_range(40, 600), $urandom_range(140, 310), 12'h000, 1'b1);
    snapshot(1'b1);
    idle(8, 1'b1);

    // random frames with counting overlapping the drain and random backpressure
    for (int f = 0; f < 3; f++) begin
      randFrame(2000, 1'b1);
      snapshot($urandom_range(0, 1) == 1);
    end
    idle(20, 1'b1);

    // stall at index 3
    randFrame(500, 1'b0);
    snapshot(1'b1);
    idle(3, 1'b1);
    idle(3, 1'b0);
    idle(6, 1'b1);

    // overrun: second frame's snapshot arrives while the first is still stalled
    randFrame(300, 1'b0);
    snapshot(1'b0);
    for (int i = 0; i < 300; i++) randPix(1'b0);
    snapshot(1'b0);
    for (int i = 0; i < 100; i++) randPix(1'b0);
    randFrame(300, 1'b1);
    snapshot(1'b1);
    idle(10, 1'b1);

    // reset while draining index 2
    randFrame(300, 1'b0);
    snapshot(1'b1);
    idle(2, 1'b1);
    doReset();
    idle(3, 1'b1);
    randFrame(300, 1'b0);
    snapshot(1'b1);
    idle(8, 1'b1);

    // saturation of window 0, partial fill of window 5
    for (int i = 0; i < 16400; i++) step(1'b1, 60, 200, 12'hFFF, 1'b1);
    for (int i = 0; i < 50; i++) step(1'b1, 589, 299, 12'h0FF, 1'b1);
    snapshot(1'b1);
    idle(8, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
